// File: rtl/xadc_drp_pkg.sv
// Shared constants and types for the XADC DRP responder: register map,
// config bit positions and the DRP transaction state encoding.
package xadc_drp_pkg;

  localparam int DEFAULT_SAMPLE_BITS = 12;
  localparam int DEFAULT_DATA_BITS   = 16;
  localparam int DEFAULT_ADDR_BITS   = 7;

  localparam logic [DEFAULT_ADDR_BITS-1:0] CH1_ADDR    = 7'h13;
  localparam logic [DEFAULT_ADDR_BITS-1:0] CH2_ADDR    = 7'h1B;
  localparam logic [DEFAULT_ADDR_BITS-1:0] CONFIG_ADDR = 7'h40;

  localparam int CFG_CONV_ENABLE_BIT = 0;
  localparam int CFG_CLEAR_ERROR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } drp_state_e;

endpackage

// File: rtl/xadc_conversion_timer.sv
// Free-running conversion period counter: latches both channel samples on
// terminal count and pulses end-of-conversion on the cycle after the latch.
module xadc_conversion_timer #(
  parameter int SAMPLE_BITS       = 12,
  parameter int CONVERSION_PERIOD = 64
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   i_enable,
  input  logic [SAMPLE_BITS-1:0] i_sample1,
  input  logic [SAMPLE_BITS-1:0] i_sample2,
  output logic [SAMPLE_BITS-1:0] o_sample1,
  output logic [SAMPLE_BITS-1:0] o_sample2,
  output logic                   o_end_of_conversion
);

  localparam int CNT_W = $clog2(CONVERSION_PERIOD);

  logic [CNT_W-1:0]       r_count;
  logic [SAMPLE_BITS-1:0] r_sample1;
  logic [SAMPLE_BITS-1:0] r_sample2;
  logic                   r_latched;
  logic                   r_eoc;
  logic                   w_terminal;

  assign w_terminal = i_enable && (r_count == CNT_W'(CONVERSION_PERIOD - 1));

  // The pulse pipeline runs regardless of i_enable, so a latch that already
  // happened still announces itself even if conversions were just disabled.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_count   <= '0;
      r_sample1 <= '0;
      r_sample2 <= '0;
      r_latched <= 1'b0;
      r_eoc     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_latched <= w_terminal;
      r_eoc     <= r_latched;
      if (i_enable) begin
        r_count <= w_terminal ? '0 : r_count + 1'b1;
      end
      if (w_terminal) begin
        r_sample1 <= i_sample1;
        r_sample2 <= i_sample2;
      end
    end
  end

  assign o_sample1           = r_sample1;
  assign o_sample2           = r_sample2;
  assign o_end_of_conversion = r_eoc;

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC stand-in: periodic dual-channel sampling plus a DRP slave that answers
// reads/writes after a fixed latency and flags requests made while busy.
module xadc_drp_responder
  import xadc_drp_pkg::*;
#(
  parameter int SAMPLE_BITS       = DEFAULT_SAMPLE_BITS,
  parameter int DATA_BITS         = DEFAULT_DATA_BITS,
  parameter int DRP_ADDRESS_BITS  = DEFAULT_ADDR_BITS,
  parameter logic [DRP_ADDRESS_BITS-1:0] CHANNEL_1_ADDRESS = DRP_ADDRESS_BITS'(CH1_ADDR),
  parameter logic [DRP_ADDRESS_BITS-1:0] CHANNEL_2_ADDRESS = DRP_ADDRESS_BITS'(CH2_ADDR),
  parameter logic [DRP_ADDRESS_BITS-1:0] CONFIG_ADDRESS    = DRP_ADDRESS_BITS'(CONFIG_ADDR),
  parameter int CONVERSION_PERIOD = 64,
  parameter int READ_LATENCY      = 3
) (
  input  logic                        clock,
  input  logic                        resetN,
  input  logic [SAMPLE_BITS-1:0]      channel1Sample,
  input  logic [SAMPLE_BITS-1:0]      channel2Sample,
  input  logic                        DRPEnable,
  input  logic                        DRPWriteEnable,
  input  logic [DRP_ADDRESS_BITS-1:0] DRPAddress,
  input  logic [DATA_BITS-1:0]        DRPDataIn,
  output logic [DATA_BITS-1:0]        DRPDataOut,
  output logic                        DRPReady,
  output logic                        endOfConversion,
  output logic                        protocolError
);

  localparam int PAD_BITS = DATA_BITS - SAMPLE_BITS;
  localparam int LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  drp_state_e                  r_state;
  drp_state_e                  w_next_state;
  logic [LAT_W-1:0]            r_lat_cnt;
  logic [DRP_ADDRESS_BITS-1:0] r_addr;
  logic                        r_we;
  logic [1:0]                  r_wdata_cfg;
  logic [DATA_BITS-1:0]        r_snapshot;
  logic                        r_conv_enable;
  logic                        r_protocol_error;
  logic [DATA_BITS-1:0]        w_read_data;
  logic [SAMPLE_BITS-1:0]      w_sample1;
  logic [SAMPLE_BITS-1:0]      w_sample2;
  logic                        w_accept;
  logic                        w_busy_request;
  logic                        w_config_write;
  logic                        w_unused;

  // Only the two defined config bits are ever stored.
  assign w_unused = ^DRPDataIn[DATA_BITS-1:2];

  xadc_conversion_timer #(
    .SAMPLE_BITS       (SAMPLE_BITS),
    .CONVERSION_PERIOD (CONVERSION_PERIOD)
  ) u_timer (
    .clock               (clock),
    .resetN              (resetN),
    .i_enable            (r_conv_enable),
    .i_sample1           (channel1Sample),
    .i_sample2           (channel2Sample),
    .o_sample1           (w_sample1),
    .o_sample2           (w_sample2),
    .o_end_of_conversion (endOfConversion)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (DRPEnable) begin
          w_accept     = 1'b1;
          w_next_state = (READ_LATENCY == 1) ? ST_RESPOND : ST_WAIT;
        end
      end
      // Counter is loaded with READ_LATENCY-1; leave when it would reach 0.
      ST_WAIT:    if (r_lat_cnt == LAT_W'(1)) w_next_state = ST_RESPOND;
      ST_RESPOND: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_read_data = '0;
    if (DRPAddress == CHANNEL_1_ADDRESS) begin
      w_read_data = {w_sample1, {PAD_BITS{1'b0}}};
    end else if (DRPAddress == CHANNEL_2_ADDRESS) begin
      w_read_data = {w_sample2, {PAD_BITS{1'b0}}};
    end else if (DRPAddress == CONFIG_ADDRESS) begin
      w_read_data[CFG_CONV_ENABLE_BIT] = r_conv_enable;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_lat_cnt   <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata_cfg <= '0;
      r_snapshot  <= '0;
    end else if (w_accept) begin
      r_lat_cnt   <= LAT_W'(READ_LATENCY - 1);
      r_addr      <= DRPAddress;
      r_we        <= DRPWriteEnable;
      r_wdata_cfg <= DRPDataIn[1:0];
      r_snapshot  <= DRPWriteEnable ? '0 : w_read_data;
    end else if (r_state == ST_WAIT) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end
  end

  assign w_config_write = (r_state == ST_RESPOND) && r_we && (r_addr == CONFIG_ADDRESS);
  assign w_busy_request = DRPEnable && (r_state != ST_IDLE);

  // A new busy violation wins over a clear landing in the same cycle.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_conv_enable    <= 1'b1;
      r_protocol_error <= 1'b0;
    end else begin
      if (w_config_write) r_conv_enable <= r_wdata_cfg[CFG_CONV_ENABLE_BIT];
      if (w_busy_request) begin
        r_protocol_error <= 1'b1;
      end else if (w_config_write && r_wdata_cfg[CFG_CLEAR_ERROR_BIT]) begin
        r_protocol_error <= 1'b0;
      end
    end
  end

  assign DRPReady      = (r_state == ST_RESPOND);
  assign DRPDataOut    = DRPReady ? r_snapshot : '0;
  assign protocolError = r_protocol_error;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Scoreboard bench for xadc_drp_responder: a cycle-level reference model
// predicts every DRPReady/endOfConversion; a monitor compares on negedges.
module tb_xadc_drp_responder;

  localparam int RL     = 3;
  localparam int PERIOD = 64;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [11:0] ch1, ch2;
  logic        en, we;
  logic [6:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        rdy, eoc, perr;

  logic        en1;
  logic        we1 = 1'b0;
  logic [6:0]  addr1;
  logic [15:0] din1 = 16'h0;
  logic [15:0] dout1;
  logic        rdy1, perr1, d1_eoc_unused;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t rsp_q[$];
  int   eoc_q[$];

  // Reference state: what the register file and timer hold during the current cycle.
  int          m_phase    = 0;
  logic [11:0] m_s1       = '0;
  logic [11:0] m_s2       = '0;
  logic        m_en       = 1'b1;
  logic        m_perr     = 1'b0;
  int          m_busy_end = -1;
  logic        m_wr_valid = 1'b0;
  int          m_wr_due   = 0;
  logic [6:0]  m_wr_addr  = '0;
  logic [15:0] m_wr_data  = '0;

  xadc_drp_responder #(.READ_LATENCY(RL), .CONVERSION_PERIOD(PERIOD)) dut (
    .clock(clock), .resetN(resetN),
    .channel1Sample(ch1), .channel2Sample(ch2),
    .DRPEnable(en), .DRPWriteEnable(we), .DRPAddress(addr), .DRPDataIn(din),
    .DRPDataOut(dout), .DRPReady(rdy), .endOfConversion(eoc), .protocolError(perr)
  );

  xadc_drp_responder #(.READ_LATENCY(1)) dut1 (
    .clock(clock), .resetN(resetN),
    .channel1Sample(ch1), .channel2Sample(ch2),
    .DRPEnable(en1), .DRPWriteEnable(we1), .DRPAddress(addr1), .DRPDataIn(din1),
    .DRPDataOut(dout1), .DRPReady(rdy1), .endOfConversion(d1_eoc_unused), .protocolError(perr1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [6:0] a);
    case (a)
      7'h13:   return {m_s1, 4'h0};
      7'h1B:   return {m_s2, 4'h0};
      7'h40:   return {15'h0, m_en};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_s1 = '0; m_s2 = '0; m_en = 1'b1; m_perr = 1'b0;
    m_busy_end = -1; m_wr_valid = 1'b0;
    rsp_q.delete();
    eoc_q.delete();
  endtask

  // Advance the model across the edge that ends cycle c.
  task automatic model_step(input int c);
    logic en_c, set_err, clr_err;
    exp_t e;
    en_c = m_en; set_err = 1'b0; clr_err = 1'b0;
    if (en) begin
      if (c <= m_busy_end) set_err = 1'b1;
      else begin
        e.data = we ? 16'h0 : model_read(addr);
        e.due  = c + RL;
        rsp_q.push_back(e);
        m_busy_end = c + RL;
        if (we) begin
          m_wr_valid = 1'b1; m_wr_due = c + RL; m_wr_addr = addr; m_wr_data = din;
        end
      end
    end
    if (m_wr_valid && c == m_wr_due) begin
      m_wr_valid = 1'b0;
      if (m_wr_addr == 7'h40) begin
        m_en    = m_wr_data[0];
        clr_err = m_wr_data[1];
      end
    end
    if (en_c) begin
      if (m_phase == PERIOD - 1) begin
        m_s1 = ch1; m_s2 = ch2; m_phase = 0;
        eoc_q.push_back(c + 2);
      end else m_phase++;
    end
    if (set_err) m_perr = 1'b1;
    else if (clr_err) m_perr = 1'b0;
  endtask

  always @(posedge clock or negedge resetN) begin
    if (!resetN) model_reset();
    else model_step(cyc);
  end

  // Monitor: compares DUT strobes against the expectation queues.
  always @(negedge clock) begin
    if (resetN) begin
      logic exp_rdy, exp_eoc;
      exp_rdy = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
      if (rdy || exp_rdy) begin
        check("drp_ready", rdy, exp_rdy);
        if (rdy && exp_rdy) check("drp_data", dout, rsp_q[0].data);
        check("protocol_error", perr, m_perr);
      end
      if (exp_rdy) void'(rsp_q.pop_front());
      exp_eoc = (eoc_q.size() > 0) && (eoc_q[0] == cyc);
      if (eoc || exp_eoc) check("end_of_conversion", eoc, exp_eoc);
      if (exp_eoc) void'(eoc_q.pop_front());
    end
  end

  // Issue one transaction from an idle cycle; returns what was seen N+RL.
  task automatic drp(input logic w, input logic [6:0] a, input logic [15:0] d,
                     input logic dup, output logic [15:0] rdata, output logic rdy_seen);
    en = 1'b1; we = w; addr = a; din = d;
    @(posedge clock); #1;
    if (dup) begin
      we = 1'b0; addr = 7'h40;
      @(posedge clock); #1;
    end
    en = 1'b0; we = 1'($urandom_range(0, 1)); addr = 7'($urandom); din = 16'($urandom);
    repeat (RL - 1 - (dup ? 1 : 0)) @(posedge clock);
    @(negedge clock);
    rdata = dout; rdy_seen = rdy;
    @(posedge clock); #1;
  endtask

  task automatic rd(input string nm, input logic [6:0] a, input logic [15:0] exp);
    logic [15:0] d; logic r;
    drp(1'b0, a, 16'h0, 1'b0, d, r);
    check({nm, "_ready"}, r, 1);
    check({nm, "_data"}, d, exp);
  endtask

  task automatic wr(input string nm, input logic [6:0] a, input logic [15:0] dt);
    logic [15:0] d; logic r;
    drp(1'b1, a, dt, 1'b0, d, r);
    check({nm, "_ready"}, r, 1);
  endtask

  task automatic wait_eoc(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (eoc) begin at = cyc; break; end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, rel, cnt, gap, pick;
    logic w, dup, rr;
    logic [6:0] a;
    logic [15:0] dd, rdd;
    logic [11:0] v1, v2;

    en = 0; we = 0; addr = 0; din = 0; en1 = 0; addr1 = 0;
    ch1 = 12'h7FF; ch2 = 12'h800;
    repeat (3) @(negedge clock);
    check("reset_ready", rdy, 0);
    check("reset_data", dout, 0);
    check("reset_eoc", eoc, 0);
    check("reset_perr", perr, 0);
    @(posedge clock); #1;
    resetN = 1'b1;
    rel = cyc;

    wait_eoc(t);
    check("first_eoc_delay", t - rel, 65);
    rd("ch1_read", 7'h13, 16'h7FF0);
    rd("ch2_read", 7'h1B, 16'h8000);

    wr("cfg_disable", 7'h40, 16'h0000);
    cnt = 0;
    repeat (200) begin
      @(negedge clock);
      if (eoc) cnt++;
    end
    @(posedge clock); #1;
    check("eoc_while_disabled", cnt, 0);
    rd("cfg_readback_off", 7'h40, 16'h0000);
    wr("cfg_enable", 7'h40, 16'h0001);
    wait_eoc(t);
    check("eoc_resumed", t >= 0, 1);

    drp(1'b0, 7'h13, 16'h0, 1'b1, rdd, rr);
    check("busy_txn_ready", rr, 1);
    check("perr_set", perr, 1);
    wr("cfg_clear_err", 7'h40, 16'h0003);
    check("perr_cleared", perr, 0);
    rd("cfg_readback_on", 7'h40, 16'h0001);

    rd("unmapped_00", 7'h00, 16'h0000);
    rd("unmapped_7f", 7'h7F, 16'h0000);
    wr("write_sample_addr", 7'h13, 16'hFFFF);
    wr("write_unmapped", 7'h22, 16'h1234);

    ch1 = 12'h100;
    wait_eoc(t);
    wait_eoc(t);
    ch1 = 12'h200;
    cnt = 0;
    while (m_phase != PERIOD - 1 && cnt < 200) begin
      @(posedge clock); #1; cnt++;
    end
    rd("snapshot_old", 7'h13, 16'h1000);
    rd("snapshot_new", 7'h13, 16'h2000);

    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 4);
      repeat (gap) begin
        ch1 = 12'($urandom); ch2 = 12'($urandom);
        @(posedge clock); #1;
      end
      pick = $urandom_range(0, 4);
      a = (pick == 0) ? 7'h13 : (pick == 1) ? 7'h1B : (pick == 2) ? 7'h40 : 7'($urandom);
      w = ($urandom_range(0, 3) == 0);
      dd = 16'($urandom);
      if (w && a == 7'h40) dd[0] = ($urandom_range(0, 3) != 0);
      dup = ($urandom_range(0, 7) == 0);
      drp(w, a, dd, dup, rdd, rr);
      check("rand_ready", rr, 1);
    end
    wr("cfg_restore", 7'h40, 16'h0003);

    en = 1'b1; we = 1'b0; addr = 7'h13;
    @(posedge clock); #1;
    en = 1'b0;
    resetN = 1'b0;
    @(negedge clock);
    check("abort_ready", rdy, 0);
    check("abort_data", dout, 0);
    check("abort_eoc", eoc, 0);
    check("abort_perr", perr, 0);
    @(posedge clock); #1;
    resetN = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (rdy) cnt++;
    end
    @(posedge clock); #1;
    check("abort_no_ready", cnt, 0);

    wait_eoc(t);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      v1 = 12'(k * 173 + 5);
      v2 = 12'(2048 - k * 97);
      ch1 = v1; ch2 = v2;
      wait_eoc(t);
      if (t >= 0) cnt++;
      rd("e2e_ch1", 7'h13, {v1, 4'h0});
      rd("e2e_ch2", 7'h1B, {v2, 4'h0});
    end
    check("e2e_conversions", cnt, 20);

    en1 = 1'b1; addr1 = 7'h40;
    @(negedge clock);
    check("rl1_not_early", rdy1, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("rl1_ready", rdy1, 1);
    check("rl1_data", dout1, 16'h0001);
    @(posedge clock); #1;
    en1 = 1'b0;
    @(negedge clock);
    check("rl1_rejected", rdy1, 0);
    check("rl1_perr", perr1, 1);

    repeat (5) @(posedge clock);
    #1;
    check("scoreboard_drained", rsp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
